// File: rtl/upsample_writeback.sv
// upsample_writeback
//   Downstream stage of the upsample block. Takes the doubled-size feature
//   stream (one PE_ARRAY_SIZE-lane beat per upsampled pixel), parks it in a
//   small skid FIFO and turns it into addressed write requests for the
//   feature buffer. One `start` covers one upsampled frame of
//   (2*row_size) rows by (2*col_size) beats in raster order.
//
// Ports
//   system_clk, rst_n    clock, asynchronous active-low reset
//   start                one-cycle pulse: latch config and begin a frame (IDLE only)
//   base_addr            address of upsampled pixel (0,0)
//   line_stride          address step between upsampled rows
//   col_size, row_size   pre-upsample frame size
//   in_feature(_valid)   pushed beat (not gated by in_ready)
//   in_ready             registered back-pressure hint to the upsampler
//   wr_addr/wr_data/wr_valid/wr_ready   write request port
//   busy, done           frame in progress / one-cycle completion pulse
//   overflow_err         sticky: a beat was dropped
//   stall_cycles         write-stall counter (only when enabled)
//
// Optional feature macro: UPSAMPLE_WB_STALL_CNT_EN enables the stall counter;
// without it stall_cycles is tied to zero.

`ifndef FEATURE_WIDTH
`define FEATURE_WIDTH 8
`endif
`ifndef PE_ARRAY_SIZE
`define PE_ARRAY_SIZE 4
`endif

module upsample_writeback #(
  parameter int FEATURE_WIDTH       = `FEATURE_WIDTH,
  parameter int PE_ARRAY_SIZE       = `PE_ARRAY_SIZE,
  parameter int FEATURE_TOTAL_WIDTH = FEATURE_WIDTH * PE_ARRAY_SIZE,
  parameter int ADDR_WIDTH          = 32,
  parameter int SKID_DEPTH          = 4
) (
  input  logic                           system_clk,
  input  logic                           rst_n,
  input  logic                           start,
  input  logic [ADDR_WIDTH-1:0]          base_addr,
  input  logic [ADDR_WIDTH-1:0]          line_stride,
  input  logic [9:0]                     col_size,
  input  logic [9:0]                     row_size,
  input  logic [FEATURE_TOTAL_WIDTH-1:0] in_feature,
  input  logic                           in_feature_valid,
  output logic                           in_ready,
  output logic [ADDR_WIDTH-1:0]          wr_addr,
  output logic [FEATURE_TOTAL_WIDTH-1:0] wr_data,
  output logic                           wr_valid,
  input  logic                           wr_ready,
  output logic                           busy,
  output logic                           done,
  output logic                           overflow_err,
  output logic [31:0]                    stall_cycles
);

  localparam int PTR_W = $clog2(SKID_DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t state_q, state_d;

  logic [FEATURE_TOTAL_WIDTH-1:0] fifo_mem [SKID_DEPTH];
  logic [PTR_W-1:0]               rd_ptr, wr_ptr;
  logic [PTR_W:0]                 fifo_count, count_next;

  logic [10:0]           cols2, rows2, col_cnt;
  logic [21:0]           total_beats, push_count, wr_count;
  logic [ADDR_WIDTH-1:0] row_base, line_stride_q;

  logic start_ok, fifo_full, fifo_empty, out_free;
  logic pop, push, drop, accept, last_accept;

  logic                           wr_valid_q, in_ready_q, overflow_q;
  logic [ADDR_WIDTH-1:0]          wr_addr_q;
  logic [FEATURE_TOTAL_WIDTH-1:0] wr_data_q;

  // Handshake decode. A pop moves the FIFO head into the output register
  // whenever that register is empty or being drained this cycle. A push is
  // taken only in RUN, only while the frame still needs beats, and only if a
  // slot is free after this cycle's pop; every other valid beat is dropped.
  always_comb begin
    start_ok    = start && (state_q == S_IDLE);
    total_beats = 22'(cols2) * 22'(rows2);
    fifo_full   = (fifo_count == (PTR_W+1)'(SKID_DEPTH));
    fifo_empty  = (fifo_count == '0);
    out_free    = !wr_valid_q || wr_ready;
    pop         = (state_q == S_RUN) && out_free && !fifo_empty;
    push        = in_feature_valid && (state_q == S_RUN) &&
                  (push_count < total_beats) && (!fifo_full || pop);
    drop        = in_feature_valid && !push;
    accept      = wr_valid_q && wr_ready;
    last_accept = (state_q == S_RUN) && accept &&
                  (wr_count == total_beats - 22'd1);
    count_next  = fifo_count + (PTR_W+1)'(push) - (PTR_W+1)'(pop);
  end

  // Frame sequencing: an empty frame skips straight to DONE, otherwise RUN
  // lasts until the final write is accepted, and DONE lasts a single cycle.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (col_size == '0 || row_size == '0) state_d = S_DONE;
          else                                  state_d = S_RUN;
        end
      end
      S_RUN:   if (last_accept) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge system_clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Frame configuration and progress counters. The address is built
  // incrementally: row_base holds base + r*stride and col_cnt the column of
  // the next beat to be loaded into the output register.
  always_ff @(posedge system_clk or negedge rst_n) begin
    if (!rst_n) begin
      cols2         <= '0;
      rows2         <= '0;
      line_stride_q <= '0;
      row_base      <= '0;
      col_cnt       <= '0;
      push_count    <= '0;
      wr_count      <= '0;
    end else if (start_ok) begin
      cols2         <= {col_size, 1'b0};
      rows2         <= {row_size, 1'b0};
      line_stride_q <= line_stride;
      row_base      <= base_addr;
      col_cnt       <= '0;
      push_count    <= '0;
      wr_count      <= '0;
    end else begin
      if (push)   push_count <= push_count + 22'd1;
      if (accept) wr_count   <= wr_count + 22'd1;
      if (pop) begin
        if (col_cnt == cols2 - 11'd1) begin
          col_cnt  <= '0;
          row_base <= row_base + line_stride_q;
        end else begin
          col_cnt <= col_cnt + 11'd1;
        end
      end
    end
  end

  // Skid FIFO storage; contents need no reset because the pointers define
  // what is valid.
  always_ff @(posedge system_clk) begin
    if (push) fifo_mem[wr_ptr] <= in_feature;
  end

  // Skid FIFO pointers and occupancy. in_ready looks at the occupancy after
  // this cycle's push/pop so that two more beats arriving after it falls
  // still find room.
  always_ff @(posedge system_clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      fifo_count <= '0;
      in_ready_q <= 1'b0;
    end else begin
      if (start_ok) begin
        rd_ptr     <= '0;
        wr_ptr     <= '0;
        fifo_count <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + PTR_W'(1);
        if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
        fifo_count <= count_next;
      end
      in_ready_q <= (state_d == S_RUN) &&
                    (count_next <= (PTR_W+1)'(SKID_DEPTH - 3));
    end
  end

  // Output register: holds address/data/valid steady while the sink stalls,
  // reloads from the FIFO head once the current request is gone.
  always_ff @(posedge system_clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_valid_q <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
    end else if (out_free) begin
      wr_valid_q <= pop;
      if (pop) begin
        wr_addr_q <= row_base + ADDR_WIDTH'(col_cnt);
        wr_data_q <= fifo_mem[rd_ptr];
      end
    end
  end

  // Sticky lost-beat flag. A beat dropped in the same cycle as `start` still
  // counts as lost, so setting wins over clearing.
  always_ff @(posedge system_clk or negedge rst_n) begin
    if (!rst_n)        overflow_q <= 1'b0;
    else if (drop)     overflow_q <= 1'b1;
    else if (start_ok) overflow_q <= 1'b0;
  end

`ifdef UPSAMPLE_WB_STALL_CNT_EN
  logic [31:0] stall_q;

  // Saturating count of RUN cycles in which a write request waits on the sink.
  always_ff @(posedge system_clk or negedge rst_n) begin
    if (!rst_n)
      stall_q <= '0;
    else if (start_ok)
      stall_q <= '0;
    else if ((state_q == S_RUN) && wr_valid_q && !wr_ready && (stall_q != '1))
      stall_q <= stall_q + 32'd1;
  end

  assign stall_cycles = stall_q;
`else
  assign stall_cycles = '0;
`endif

  assign in_ready     = in_ready_q;
  assign wr_valid     = wr_valid_q;
  assign wr_addr      = wr_addr_q;
  assign wr_data      = wr_data_q;
  assign overflow_err = overflow_q;
  assign busy         = (state_q != S_IDLE);
  assign done         = (state_q == S_DONE);

endmodule

// File: tb/tb_upsample_writeback.sv
// tb_upsample_writeback
//   Self-checking bench for upsample_writeback. A source model emits random
//   beats and keeps sending for two cycles after in_ready falls, like the
//   upstream upsampler; a sink model drives wr_ready. Expected write order,
//   data and addresses come from the raster rule addr = base + r*stride + c.

module tb_upsample_writeback;

  localparam int FW = 8;
  localparam int PE = 4;
  localparam int TW = FW * PE;
  localparam int AW = 32;

  logic          system_clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic [AW-1:0] base_addr;
  logic [AW-1:0] line_stride;
  logic [9:0]    col_size;
  logic [9:0]    row_size;
  logic [TW-1:0] in_feature;
  logic          in_feature_valid;
  logic          in_ready;
  logic [AW-1:0] wr_addr;
  logic [TW-1:0] wr_data;
  logic          wr_valid;
  logic          wr_ready;
  logic          busy;
  logic          done;
  logic          overflow_err;
  logic [31:0]   stall_cycles;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  logic [TW-1:0] exp_data[$];
  logic [AW-1:0] obs_addr[$];
  logic [TW-1:0] obs_data[$];
  int            obs_cyc[$];
  int            done_count, done_cyc, start_cyc, first_push_cyc, first_wv_cyc;
  bit            timed_out, ovf_seen, wv_seen, first_in_ready, first_busy;

  upsample_writeback #(
    .FEATURE_WIDTH(FW),
    .PE_ARRAY_SIZE(PE),
    .ADDR_WIDTH(AW),
    .SKID_DEPTH(4)
  ) dut (
    .system_clk(system_clk),
    .rst_n(rst_n),
    .start(start),
    .base_addr(base_addr),
    .line_stride(line_stride),
    .col_size(col_size),
    .row_size(row_size),
    .in_feature(in_feature),
    .in_feature_valid(in_feature_valid),
    .in_ready(in_ready),
    .wr_addr(wr_addr),
    .wr_data(wr_data),
    .wr_valid(wr_valid),
    .wr_ready(wr_ready),
    .busy(busy),
    .done(done),
    .overflow_err(overflow_err),
    .stall_cycles(stall_cycles)
  );

  // Free-running clock and cycle index used to time-stamp observations.
  always #5 system_clk = ~system_clk;

  always @(posedge system_clk) cyc <= cyc + 1;

  // Raster-order address of the idx-th write of a frame with cols2 beats/row.
  function automatic logic [AW-1:0] model_addr(input logic [AW-1:0] base,
                                               input logic [AW-1:0] stride,
                                               input int idx, input int cols2);
    int r;
    int c;
    r = idx / cols2;
    c = idx % cols2;
    return base + stride * AW'(r) + AW'(c);
  endfunction

  // Starts a frame and plays source and sink models until done (or until
  // max_writes writes were seen), recording every observed write.
  task automatic run_frame(input int col, input int row,
                           input logic [AW-1:0] base, input logic [AW-1:0] stride,
                           input int stall_at, input int stall_len,
                           input bit rand_mode, input int max_writes);
    int  total;
    int  sent;
    int  stall_rem;
    bit  stalled, r1, r2, vin, rdy, finished, first_iter;
    total = 4 * col * row;
    sent = 0; stall_rem = 0; stalled = 0; r1 = 0; r2 = 0;
    finished = 0; first_iter = 1;
    exp_data.delete(); obs_addr.delete(); obs_data.delete(); obs_cyc.delete();
    done_count = 0; done_cyc = -1; first_push_cyc = -1; first_wv_cyc = -1;
    timed_out = 0; ovf_seen = 0; wv_seen = 0;
    @(negedge system_clk);
    base_addr = base; line_stride = stride;
    col_size = 10'(col); row_size = 10'(row);
    start = 1'b1; in_feature_valid = 1'b0; wr_ready = 1'b1;
    start_cyc = cyc;
    for (int it = 0; it < 2000 && !finished; it++) begin
      @(negedge system_clk);
      start = 1'b0;
      if (first_iter) begin
        first_in_ready = in_ready;
        first_busy = busy;
        first_iter = 0;
      end
      if (done) begin done_count++; done_cyc = cyc; end
      if (wr_valid) begin
        wv_seen = 1;
        if (first_wv_cyc < 0) first_wv_cyc = cyc;
      end
      if (overflow_err) ovf_seen = 1;
      if (done) begin
        in_feature_valid = 1'b0;
        finished = 1;
      end else begin
        if (stall_rem > 0) begin
          rdy = 1'b0; stall_rem--;
        end else if (stall_len > 0 && !stalled && obs_addr.size() >= stall_at && wr_valid) begin
          rdy = 1'b0; stalled = 1; stall_rem = stall_len - 1;
        end else if (rand_mode) begin
          rdy = ($urandom_range(0, 2) != 0);
        end else begin
          rdy = 1'b1;
        end
        vin = (sent < total) && (in_ready || r1 || r2);
        if (rand_mode && $urandom_range(0, 3) == 0) vin = 1'b0;
        wr_ready = rdy;
        in_feature_valid = vin;
        if (vin) begin
          in_feature = $urandom;
          exp_data.push_back(in_feature);
          sent++;
          if (first_push_cyc < 0) first_push_cyc = cyc;
        end
        if (wr_valid && rdy) begin
          obs_addr.push_back(wr_addr);
          obs_data.push_back(wr_data);
          obs_cyc.push_back(cyc);
        end
        r2 = r1;
        r1 = in_ready;
        if (max_writes > 0 && obs_addr.size() >= max_writes) finished = 1;
      end
    end
    if (!finished) timed_out = 1;
    if (max_writes == 0) begin
      wr_ready = 1'b1;
      repeat (3) begin
        @(negedge system_clk);
        if (done) done_count++;
        if (wr_valid) wv_seen = 1;
      end
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0; start = 1'b0; in_feature_valid = 1'b0; wr_ready = 1'b0;
    in_feature = '0; base_addr = '0; line_stride = '0; col_size = '0; row_size = '0;
    repeat (3) @(negedge system_clk);
    checks++; if (in_ready !== 1'b0) begin errors++; $display("[TB] FAIL reset_in_ready: got %0b expected 0", in_ready); end
    checks++; if (wr_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_wr_valid: got %0b expected 0", wr_valid); end
    checks++; if (wr_addr !== '0) begin errors++; $display("[TB] FAIL reset_wr_addr: got %0h expected 0", wr_addr); end
    checks++; if (wr_data !== '0) begin errors++; $display("[TB] FAIL reset_wr_data: got %0h expected 0", wr_data); end
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy: got %0b expected 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("[TB] FAIL reset_done: got %0b expected 0", done); end
    checks++; if (overflow_err !== 1'b0) begin errors++; $display("[TB] FAIL reset_overflow: got %0b expected 0", overflow_err); end
    checks++; if (stall_cycles !== 32'd0) begin errors++; $display("[TB] FAIL reset_stall: got %0d expected 0", stall_cycles); end
    rst_n = 1'b1;
    repeat (2) @(negedge system_clk);
  endtask

  task automatic test_basic_frame;
    logic [AW-1:0] ea;
    int n;
    $display("[TB] basic 2x2 frame");
    run_frame(2, 2, 32'h100, 32'h10, 0, 0, 1'b0, 0);
    checks++; if (timed_out) begin errors++; $display("[TB] FAIL basic_timeout: got timeout expected done"); end
    checks++; if (first_in_ready !== 1'b1) begin errors++; $display("[TB] FAIL basic_in_ready_first: got %0b expected 1", first_in_ready); end
    checks++; if (first_busy !== 1'b1) begin errors++; $display("[TB] FAIL basic_busy_first: got %0b expected 1", first_busy); end
    checks++; if (obs_addr.size() != 16) begin errors++; $display("[TB] FAIL basic_write_count: got %0d expected 16", obs_addr.size()); end
    n = (obs_addr.size() < 16) ? obs_addr.size() : 16;
    for (int i = 0; i < n; i++) begin
      ea = 32'h100 + 32'h10 * AW'(i / 4) + AW'(i % 4);
      checks++; if (obs_addr[i] !== ea) begin errors++; $display("[TB] FAIL basic_addr[%0d]: got %0h expected %0h", i, obs_addr[i], ea); end
      checks++; if (obs_data[i] !== exp_data[i]) begin errors++; $display("[TB] FAIL basic_data[%0d]: got %0h expected %0h", i, obs_data[i], exp_data[i]); end
    end
    checks++; if (first_wv_cyc - first_push_cyc != 2) begin errors++; $display("[TB] FAIL basic_latency: got %0d expected 2", first_wv_cyc - first_push_cyc); end
    if (obs_cyc.size() == 16) begin
      checks++; if (obs_cyc[15] - obs_cyc[0] != 15) begin errors++; $display("[TB] FAIL basic_throughput: got %0d expected 15", obs_cyc[15] - obs_cyc[0]); end
      checks++; if (done_cyc != obs_cyc[15] + 1) begin errors++; $display("[TB] FAIL basic_done_timing: got %0d expected %0d", done_cyc, obs_cyc[15] + 1); end
    end
    checks++; if (done_count != 1) begin errors++; $display("[TB] FAIL basic_done_count: got %0d expected 1", done_count); end
    checks++; if (ovf_seen) begin errors++; $display("[TB] FAIL basic_overflow: got 1 expected 0"); end
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL basic_busy_end: got %0b expected 0", busy); end
  endtask

  task automatic test_stall;
    logic [31:0] exp_stall;
    logic [AW-1:0] ea;
    int n;
    $display("[TB] 3x1 frame with 20-cycle sink stall");
`ifdef UPSAMPLE_WB_STALL_CNT_EN
    exp_stall = 32'd20;
`else
    exp_stall = 32'd0;
`endif
    run_frame(3, 1, 32'h4000, 32'h80, 4, 20, 1'b0, 0);
    checks++; if (timed_out) begin errors++; $display("[TB] FAIL stall_timeout: got timeout expected done"); end
    checks++; if (obs_addr.size() != 12) begin errors++; $display("[TB] FAIL stall_write_count: got %0d expected 12", obs_addr.size()); end
    n = (obs_addr.size() < 12) ? obs_addr.size() : 12;
    for (int i = 0; i < n; i++) begin
      ea = model_addr(32'h4000, 32'h80, i, 6);
      checks++; if (obs_addr[i] !== ea) begin errors++; $display("[TB] FAIL stall_addr[%0d]: got %0h expected %0h", i, obs_addr[i], ea); end
      checks++; if (obs_data[i] !== exp_data[i]) begin errors++; $display("[TB] FAIL stall_data[%0d]: got %0h expected %0h", i, obs_data[i], exp_data[i]); end
    end
    checks++; if (overflow_err !== 1'b0 || ovf_seen) begin errors++; $display("[TB] FAIL stall_overflow: got 1 expected 0"); end
    checks++; if (stall_cycles !== exp_stall) begin errors++; $display("[TB] FAIL stall_count: got %0d expected %0d", stall_cycles, exp_stall); end
    checks++; if (done_count != 1) begin errors++; $display("[TB] FAIL stall_done_count: got %0d expected 1", done_count); end
  endtask

  task automatic test_overflow_burst;
    logic [TW-1:0] beats[$];
    logic [AW-1:0] ea;
    int sent, n;
    bit seen_done;
    $display("[TB] burst of 6 beats into a stalled sink");
    @(negedge system_clk);
    base_addr = 32'h2000; line_stride = 32'h40; col_size = 10'd1; row_size = 10'd2;
    start = 1'b1; wr_ready = 1'b0; in_feature_valid = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(negedge system_clk);
      start = 1'b0;
      wr_ready = 1'b0;
      if (k == 5) begin
        checks++; if (overflow_err !== 1'b0) begin errors++; $display("[TB] FAIL burst_no_ovf_after5: got %0b expected 0", overflow_err); end
      end
      in_feature_valid = 1'b1;
      in_feature = $urandom;
      beats.push_back(in_feature);
    end
    @(negedge system_clk);
    in_feature_valid = 1'b0;
    checks++; if (overflow_err !== 1'b1) begin errors++; $display("[TB] FAIL burst_ovf_after6: got %0b expected 1", overflow_err); end
    checks++; if (wr_valid !== 1'b1 || wr_data !== beats[0]) begin errors++; $display("[TB] FAIL burst_held_head: got %0b/%0h expected 1/%0h", wr_valid, wr_data, beats[0]); end
    void'(beats.pop_back());
    obs_addr.delete(); obs_data.delete();
    sent = 0; seen_done = 0;
    for (int it = 0; it < 60 && !seen_done; it++) begin
      if (it > 0) @(negedge system_clk);
      if (done) seen_done = 1;
      wr_ready = 1'b1;
      in_feature_valid = (sent < 3) && in_ready;
      if (in_feature_valid) begin
        in_feature = $urandom;
        beats.push_back(in_feature);
        sent++;
      end
      if (wr_valid) begin
        obs_addr.push_back(wr_addr);
        obs_data.push_back(wr_data);
      end
    end
    in_feature_valid = 1'b0;
    checks++; if (!seen_done) begin errors++; $display("[TB] FAIL burst_done: got 0 expected 1"); end
    checks++; if (obs_addr.size() != 8) begin errors++; $display("[TB] FAIL burst_write_count: got %0d expected 8", obs_addr.size()); end
    n = (obs_addr.size() < 8) ? obs_addr.size() : 8;
    for (int i = 0; i < n; i++) begin
      ea = model_addr(32'h2000, 32'h40, i, 2);
      checks++; if (obs_addr[i] !== ea) begin errors++; $display("[TB] FAIL burst_addr[%0d]: got %0h expected %0h", i, obs_addr[i], ea); end
      checks++; if (obs_data[i] !== beats[i]) begin errors++; $display("[TB] FAIL burst_data[%0d]: got %0h expected %0h", i, obs_data[i], beats[i]); end
    end
    checks++; if (overflow_err !== 1'b1) begin errors++; $display("[TB] FAIL burst_ovf_sticky: got %0b expected 1", overflow_err); end
  endtask

  task automatic test_zero_size;
    $display("[TB] empty frame col=0 row=5");
    run_frame(0, 5, 32'h0, 32'h10, 0, 0, 1'b0, 0);
    checks++; if (timed_out) begin errors++; $display("[TB] FAIL zero_timeout: got timeout expected done"); end
    checks++; if (done_cyc - start_cyc < 1 || done_cyc - start_cyc > 2) begin errors++; $display("[TB] FAIL zero_done_delay: got %0d expected 1..2", done_cyc - start_cyc); end
    checks++; if (done_count != 1) begin errors++; $display("[TB] FAIL zero_done_count: got %0d expected 1", done_count); end
    checks++; if (wv_seen) begin errors++; $display("[TB] FAIL zero_wr_valid: got 1 expected 0"); end
  endtask

  task automatic test_idle_stray;
    logic [AW-1:0] ea;
    int n;
    $display("[TB] stray beat in IDLE");
    @(negedge system_clk);
    in_feature_valid = 1'b1; in_feature = $urandom; wr_ready = 1'b1;
    @(negedge system_clk);
    in_feature_valid = 1'b0;
    checks++; if (overflow_err !== 1'b1) begin errors++; $display("[TB] FAIL stray_overflow: got %0b expected 1", overflow_err); end
    checks++; if (wr_valid !== 1'b0) begin errors++; $display("[TB] FAIL stray_wr_valid: got %0b expected 0", wr_valid); end
    run_frame(1, 1, 32'h500, 32'h20, 0, 0, 1'b0, 0);
    checks++; if (ovf_seen) begin errors++; $display("[TB] FAIL stray_ovf_cleared: got 1 expected 0"); end
    checks++; if (obs_addr.size() != 4) begin errors++; $display("[TB] FAIL stray_write_count: got %0d expected 4", obs_addr.size()); end
    n = (obs_addr.size() < 4) ? obs_addr.size() : 4;
    for (int i = 0; i < n; i++) begin
      ea = model_addr(32'h500, 32'h20, i, 2);
      checks++; if (obs_addr[i] !== ea) begin errors++; $display("[TB] FAIL stray_addr[%0d]: got %0h expected %0h", i, obs_addr[i], ea); end
    end
  endtask

  task automatic test_reset_mid_frame;
    $display("[TB] reset after 5 writes");
    run_frame(2, 2, 32'h100, 32'h10, 0, 0, 1'b0, 5);
    checks++; if (obs_addr.size() != 5) begin errors++; $display("[TB] FAIL midrst_writes: got %0d expected 5", obs_addr.size()); end
    @(posedge system_clk);
    #2;
    in_feature_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    checks++; if (wr_valid !== 1'b0 || in_ready !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin errors++; $display("[TB] FAIL midrst_ctrl: got v%0b r%0b b%0b d%0b expected all 0", wr_valid, in_ready, busy, done); end
    checks++; if (wr_addr !== '0 || wr_data !== '0) begin errors++; $display("[TB] FAIL midrst_data: got %0h/%0h expected 0/0", wr_addr, wr_data); end
    checks++; if (overflow_err !== 1'b0 || stall_cycles !== 32'd0) begin errors++; $display("[TB] FAIL midrst_status: got %0b/%0d expected 0/0", overflow_err, stall_cycles); end
    repeat (2) @(negedge system_clk);
    rst_n = 1'b1;
    done_count = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge system_clk);
      if (done || busy || wr_valid) done_count++;
    end
    checks++; if (done_count != 0) begin errors++; $display("[TB] FAIL midrst_idle: got %0d active cycles expected 0", done_count); end
  endtask

  task automatic test_random_frames;
    logic [AW-1:0] base, stride, ea;
    int col, row, n, total;
    for (int f = 0; f < 4; f++) begin
      col = $urandom_range(1, 4);
      row = $urandom_range(1, 3);
      base = $urandom;
      stride = $urandom_range(1, 8192);
      total = 4 * col * row;
      $display("[TB] random frame %0d: col=%0d row=%0d", f, col, row);
      run_frame(col, row, base, stride, 0, 0, 1'b1, 0);
      checks++; if (timed_out) begin errors++; $display("[TB] FAIL rand%0d_timeout: got timeout expected done", f); end
      checks++; if (obs_addr.size() != total) begin errors++; $display("[TB] FAIL rand%0d_write_count: got %0d expected %0d", f, obs_addr.size(), total); end
      n = (obs_addr.size() < total) ? obs_addr.size() : total;
      for (int i = 0; i < n; i++) begin
        ea = model_addr(base, stride, i, 2 * col);
        checks++; if (obs_addr[i] !== ea) begin errors++; $display("[TB] FAIL rand%0d_addr[%0d]: got %0h expected %0h", f, i, obs_addr[i], ea); end
        checks++; if (obs_data[i] !== exp_data[i]) begin errors++; $display("[TB] FAIL rand%0d_data[%0d]: got %0h expected %0h", f, i, obs_data[i], exp_data[i]); end
      end
      checks++; if (done_count != 1) begin errors++; $display("[TB] FAIL rand%0d_done_count: got %0d expected 1", f, done_count); end
      checks++; if (ovf_seen) begin errors++; $display("[TB] FAIL rand%0d_overflow: got 1 expected 0", f); end
    end
  endtask

  initial begin
    test_reset();
    test_basic_frame();
    test_stall();
    test_overflow_burst();
    test_zero_size();
    test_idle_stray();
    test_reset_mid_frame();
    test_random_frames();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
